// File: rtl/interrupt_ack_sequencer.sv
// Interrupt controller core: ICW init sequencing, mask/in-service tracking,
// fixed-priority resolution and the two-pulse INTA vector handshake.
module interrupt_ack_sequencer (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       wr_pulse,
   input  logic       a0,
   input  logic [7:0] din,
   input  logic       inta_n,
   input  logic [7:0] irr,
   output logic [7:0] imr,
   output logic [7:0] isr,
   output logic       int_out,
   output logic [7:0] clr_irr,
   output logic [7:0] vector,
   output logic       vector_oe,
   output logic       init_done
);

   localparam int unsigned NUM_IR = 8;
   localparam int unsigned LVL_W  = 3;
   localparam int unsigned BASE_W = 5;

   typedef enum logic [2:0] {WAIT_ICW1, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY} init_state_t;
   typedef enum logic [1:0] {ACK_IDLE, ACK1, ACK2} ack_state_t;

   init_state_t             init_state, init_state_n;
   ack_state_t              ack_state, ack_state_n;
   logic [NUM_IR-1:0]       imr_n, isr_n, clr_irr_n;
   logic [BASE_W-1:0]       base, base_n;
   logic [LVL_W-1:0]        level, level_n;
   logic                    aeoi, aeoi_n;
   logic                    sngl, sngl_n;
   logic                    ic4, ic4_n;
   logic                    spurious, spurious_n;
   logic                    inta_prev;

   logic [NUM_IR-1:0]       prio_mask, req, set_mask, clr_mask;
   logic [LVL_W-1:0]        isr_top;
   logic                    fall, rise, icw1, wr_a1, ocw2;

   // Index of the highest-priority (lowest-numbered) set bit; 0 when none set.
   function automatic logic [LVL_W-1:0] prio_idx(input logic [NUM_IR-1:0] v);
      logic [LVL_W-1:0] idx;
      idx = '0;
      for (int i = NUM_IR - 1; i >= 0; i--) begin
         if (v[i]) idx = LVL_W'(i);
      end
      return idx;
   endfunction

   assign init_done = (init_state == READY);
   assign isr_top   = prio_idx(isr);
   assign prio_mask = (isr == '0) ? '1 : NUM_IR'((8'd1 << isr_top) - 8'd1);
   assign req       = irr & ~imr & prio_mask;
   assign int_out   = init_done & (req != '0) & (ack_state == ACK_IDLE);

   // INTA is ignored until initialization is complete.
   assign fall  = inta_prev & ~inta_n & init_done;
   assign rise  = ~inta_prev & inta_n;

   assign icw1  = wr_pulse & ~a0 & din[4];
   assign wr_a1 = wr_pulse & a0;
   assign ocw2  = wr_pulse & ~a0 & (din[4:3] == 2'b00) & (init_state == READY);

   assign vector_oe = (ack_state == ACK2) & ~inta_n;
   assign vector    = vector_oe ? {base, level} : 8'h00;

   always_comb begin
      init_state_n = init_state;
      ack_state_n  = ack_state;
      imr_n        = imr;
      base_n       = base;
      level_n      = level;
      aeoi_n       = aeoi;
      sngl_n       = sngl;
      ic4_n        = ic4;
      spurious_n   = spurious;
      clr_irr_n    = '0;
      set_mask     = '0;
      clr_mask     = '0;

      unique case (init_state)
         WAIT_ICW2: if (wr_a1) begin
            base_n = din[7:3];
            if (!sngl)    init_state_n = WAIT_ICW3;
            else if (ic4) init_state_n = WAIT_ICW4;
            else          init_state_n = READY;
         end
         WAIT_ICW3: if (wr_a1) init_state_n = ic4 ? WAIT_ICW4 : READY;
         WAIT_ICW4: if (wr_a1) begin
            aeoi_n       = din[1];
            init_state_n = READY;
         end
         READY: begin
            if (wr_a1) imr_n = din;
            if (ocw2) begin
               if (din[7:5] == 3'b001 && isr != '0) clr_mask = NUM_IR'(8'd1 << isr_top);
               else if (din[7:5] == 3'b011)         clr_mask = NUM_IR'(8'd1 << din[2:0]);
            end
         end
         default: ;
      endcase

      unique case (ack_state)
         ACK_IDLE: if (fall) begin
            ack_state_n = ACK1;
            if (req != '0) begin
               level_n    = prio_idx(req);
               spurious_n = 1'b0;
               set_mask   = NUM_IR'(8'd1 << prio_idx(req));
               clr_irr_n  = NUM_IR'(8'd1 << prio_idx(req));
            end else begin
               level_n    = LVL_W'(NUM_IR - 1);
               spurious_n = 1'b1;
            end
         end
         ACK1: if (fall) ack_state_n = ACK2;
         ACK2: if (rise) begin
            if (aeoi && !spurious) clr_mask = clr_mask | NUM_IR'(8'd1 << level);
            ack_state_n = ACK_IDLE;
         end
         default: ack_state_n = ACK_IDLE;
      endcase

      // EOI uses the pre-edge isr; a coincident set wins.
      isr_n = (isr & ~clr_mask) | set_mask;

      // ICW1 restarts initialization from any state and aborts any acknowledge.
      if (icw1) begin
         sngl_n       = din[1];
         ic4_n        = din[0];
         imr_n        = '0;
         isr_n        = '0;
         aeoi_n       = 1'b0;
         spurious_n   = 1'b0;
         clr_irr_n    = '0;
         init_state_n = WAIT_ICW2;
         ack_state_n  = ACK_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         init_state <= WAIT_ICW1;
         ack_state  <= ACK_IDLE;
         imr        <= '0;
         isr        <= '0;
         clr_irr    <= '0;
         base       <= '0;
         level      <= '0;
         aeoi       <= 1'b0;
         sngl       <= 1'b0;
         ic4        <= 1'b0;
         spurious   <= 1'b0;
         inta_prev  <= 1'b1;
      end else begin
         init_state <= init_state_n;
         ack_state  <= ack_state_n;
         imr        <= imr_n;
         isr        <= isr_n;
         clr_irr    <= clr_irr_n;
         base       <= base_n;
         level      <= level_n;
         aeoi       <= aeoi_n;
         sngl       <= sngl_n;
         ic4        <= ic4_n;
         spurious   <= spurious_n;
         inta_prev  <= inta_n;
      end
   end

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Directed self-checking bench for interrupt_ack_sequencer.
module tb_interrupt_ack_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       wr_pulse;
   logic       a0;
   logic [7:0] din;
   logic       inta_n;
   logic [7:0] irr;
   logic [7:0] imr, isr, clr_irr, vector;
   logic       int_out, vector_oe, init_done;

   int tests = 0;
   int fails = 0;

   interrupt_ack_sequencer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_pulse  (wr_pulse),
      .a0        (a0),
      .din       (din),
      .inta_n    (inta_n),
      .irr       (irr),
      .imr       (imr),
      .isr       (isr),
      .int_out   (int_out),
      .clr_irr   (clr_irr),
      .vector    (vector),
      .vector_oe (vector_oe),
      .init_done (init_done)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Single register write, effective on the posedge inside the call.
   task automatic write(input logic sel, input logic [7:0] d);
      @(negedge clk);
      wr_pulse = 1'b1; a0 = sel; din = d;
      @(negedge clk);
      wr_pulse = 1'b0; a0 = 1'b0; din = 8'h00;
      #1;
   endtask

   // Full two-pulse acknowledge without checks, used only for setup.
   task automatic inta_pair();
      @(negedge clk); inta_n = 1'b0;
      @(negedge clk); inta_n = 1'b1;
      @(negedge clk); inta_n = 1'b0;
      @(negedge clk); inta_n = 1'b1;
      @(negedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; wr_pulse = 1'b0; a0 = 1'b0; din = 8'h00; inta_n = 1'b1; irr = 8'h00;
      repeat (3) @(negedge clk);
      #1;
      tests++; if (init_done !== 1'b0) begin fails++; $display("FAIL reset_init_done: got %b exp 0", init_done); end
      tests++; if (imr !== 8'h00) begin fails++; $display("FAIL reset_imr: got %h exp 00", imr); end
      tests++; if (vector_oe !== 1'b0) begin fails++; $display("FAIL reset_vector_oe: got %b exp 0", vector_oe); end
      rst_n = 1'b1;
      // Requests and INTA before init must be ignored.
      irr = 8'hFF;
      @(negedge clk); inta_n = 1'b0;
      @(negedge clk); #1;
      tests++; if (int_out !== 1'b0) begin fails++; $display("FAIL preinit_int_out: got %b exp 0", int_out); end
      tests++; if (clr_irr !== 8'h00) begin fails++; $display("FAIL preinit_clr_irr: got %h exp 00", clr_irr); end
      tests++; if (isr !== 8'h00) begin fails++; $display("FAIL preinit_isr: got %h exp 00", isr); end
      inta_n = 1'b1; irr = 8'h00;
      @(negedge clk);
   endtask

   task automatic test_init();
      write(1'b0, 8'h13);
      tests++; if (init_done !== 1'b0) begin fails++; $display("FAIL init_after_icw1: got %b exp 0", init_done); end
      write(1'b1, 8'h40);
      tests++; if (init_done !== 1'b0) begin fails++; $display("FAIL init_after_icw2: got %b exp 0", init_done); end
      write(1'b1, 8'h01);
      tests++; if (init_done !== 1'b1) begin fails++; $display("FAIL init_done: got %b exp 1", init_done); end
      tests++; if (imr !== 8'h00) begin fails++; $display("FAIL init_imr: got %h exp 00", imr); end
   endtask

   task automatic test_ack_sequence();
      @(negedge clk); irr = 8'h24; #1;
      tests++; if (int_out !== 1'b1) begin fails++; $display("FAIL ack_int_out_pending: got %b exp 1", int_out); end
      @(negedge clk); inta_n = 1'b0;
      @(negedge clk); #1;
      tests++; if (clr_irr !== 8'h04) begin fails++; $display("FAIL ack_clr_irr: got %h exp 04", clr_irr); end
      tests++; if (isr !== 8'h04) begin fails++; $display("FAIL ack_isr: got %h exp 04", isr); end
      tests++; if (int_out !== 1'b0) begin fails++; $display("FAIL ack_int_out_low: got %b exp 0", int_out); end
      tests++; if (vector_oe !== 1'b0) begin fails++; $display("FAIL ack_oe_first_low: got %b exp 0", vector_oe); end
      irr = 8'h20; inta_n = 1'b1;
      @(negedge clk); #1;
      tests++; if (clr_irr !== 8'h00) begin fails++; $display("FAIL ack_clr_irr_one_cycle: got %h exp 00", clr_irr); end
      inta_n = 1'b0; #1;
      tests++; if (vector_oe !== 1'b0) begin fails++; $display("FAIL ack_oe_before_ack2: got %b exp 0", vector_oe); end
      @(negedge clk); #1;
      tests++; if (vector_oe !== 1'b1) begin fails++; $display("FAIL ack_oe_second_low: got %b exp 1", vector_oe); end
      tests++; if (vector !== 8'h42) begin fails++; $display("FAIL ack_vector: got %h exp 42", vector); end
      inta_n = 1'b1; #1;
      tests++; if (vector !== 8'h00 || vector_oe !== 1'b0) begin fails++; $display("FAIL ack_release: got vector %h oe %b exp 00 0", vector, vector_oe); end
      @(negedge clk); #1;
      tests++; if (isr !== 8'h04) begin fails++; $display("FAIL ack_isr_held: got %h exp 04", isr); end
      tests++; if (int_out !== 1'b0) begin fails++; $display("FAIL ack_lower_blocked: got %b exp 0", int_out); end
   endtask

   task automatic test_eoi();
      write(1'b0, 8'h20);
      tests++; if (isr !== 8'h00) begin fails++; $display("FAIL eoi_isr: got %h exp 00", isr); end
      tests++; if (int_out !== 1'b1) begin fails++; $display("FAIL eoi_int_out: got %b exp 1", int_out); end
      irr = 8'h00;
   endtask

   task automatic test_spurious();
      write(1'b1, 8'hFF);
      irr = 8'h01; #1;
      tests++; if (int_out !== 1'b0) begin fails++; $display("FAIL masked_int_out: got %b exp 0", int_out); end
      @(negedge clk); inta_n = 1'b0;
      @(negedge clk); #1;
      tests++; if (clr_irr !== 8'h00) begin fails++; $display("FAIL spurious_clr_irr: got %h exp 00", clr_irr); end
      inta_n = 1'b1;
      @(negedge clk); inta_n = 1'b0;
      @(negedge clk); #1;
      tests++; if (vector !== 8'h47) begin fails++; $display("FAIL spurious_vector: got %h exp 47", vector); end
      inta_n = 1'b1;
      @(negedge clk); #1;
      tests++; if (isr !== 8'h00) begin fails++; $display("FAIL spurious_isr: got %h exp 00", isr); end
      write(1'b1, 8'h00);
      irr = 8'h00;
   endtask

   task automatic test_same_cycle_eoi_set();
      irr = 8'h04;
      inta_pair();
      irr = 8'h01; #1;
      tests++; if (int_out !== 1'b1) begin fails++; $display("FAIL nest_int_out: got %b exp 1", int_out); end
      @(negedge clk);
      inta_n = 1'b0; wr_pulse = 1'b1; a0 = 1'b0; din = 8'h20;
      @(negedge clk);
      wr_pulse = 1'b0; din = 8'h00; #1;
      tests++; if (isr !== 8'h01) begin fails++; $display("FAIL same_cycle_isr: got %h exp 01", isr); end
      tests++; if (clr_irr !== 8'h01) begin fails++; $display("FAIL same_cycle_clr_irr: got %h exp 01", clr_irr); end
      inta_n = 1'b1; irr = 8'h00;
      @(negedge clk); inta_n = 1'b0;
      @(negedge clk); #1;
      tests++; if (vector !== 8'h40) begin fails++; $display("FAIL same_cycle_vector: got %h exp 40", vector); end
      inta_n = 1'b1;
      @(negedge clk);
      write(1'b0, 8'h60);
      tests++; if (isr !== 8'h00) begin fails++; $display("FAIL specific_eoi_isr: got %h exp 00", isr); end
   endtask

   task automatic test_aeoi();
      write(1'b0, 8'h13);
      write(1'b1, 8'h40);
      write(1'b1, 8'h03);
      irr = 8'h80;
      @(negedge clk); inta_n = 1'b0;
      @(negedge clk); #1;
      tests++; if (isr !== 8'h80) begin fails++; $display("FAIL aeoi_isr_set: got %h exp 80", isr); end
      irr = 8'h00; inta_n = 1'b1;
      @(negedge clk); inta_n = 1'b0;
      @(negedge clk); #1;
      tests++; if (vector !== 8'h47) begin fails++; $display("FAIL aeoi_vector: got %h exp 47", vector); end
      inta_n = 1'b1;
      @(negedge clk); #1;
      tests++; if (isr !== 8'h00) begin fails++; $display("FAIL aeoi_isr_clear: got %h exp 00", isr); end
   endtask

   task automatic test_icw1_abort();
      irr = 8'h02;
      @(negedge clk); inta_n = 1'b0;
      @(negedge clk); inta_n = 1'b1;
      @(negedge clk); inta_n = 1'b0;
      @(negedge clk); #1;
      tests++; if (vector_oe !== 1'b1 || vector !== 8'h41) begin fails++; $display("FAIL abort_in_ack2: got vector %h oe %b exp 41 1", vector, vector_oe); end
      write(1'b0, 8'h12);
      tests++; if (vector_oe !== 1'b0) begin fails++; $display("FAIL abort_vector_oe: got %b exp 0", vector_oe); end
      tests++; if (isr !== 8'h00) begin fails++; $display("FAIL abort_isr: got %h exp 00", isr); end
      tests++; if (init_done !== 1'b0) begin fails++; $display("FAIL abort_init_done: got %b exp 0", init_done); end
      inta_n = 1'b1;
      write(1'b1, 8'h40);
      tests++; if (init_done !== 1'b1) begin fails++; $display("FAIL abort_to_icw2: got %b exp 1", init_done); end
      tests++; if (int_out !== 1'b1) begin fails++; $display("FAIL abort_reinit_int_out: got %b exp 1", int_out); end
      irr = 8'h00;
   endtask

   task automatic test_async_reset();
      write(1'b1, 8'h0E);
      irr = 8'h01;
      @(negedge clk); inta_n = 1'b0;
      @(posedge clk); #2;
      tests++; if (clr_irr !== 8'h01) begin fails++; $display("FAIL rst_pre_clr_irr: got %h exp 01", clr_irr); end
      rst_n = 1'b0; #1;
      tests++; if (imr !== 8'h00 || isr !== 8'h00 || clr_irr !== 8'h00) begin
         fails++; $display("FAIL async_rst_regs: got imr %h isr %h clr %h exp 00 00 00", imr, isr, clr_irr); end
      tests++; if (int_out !== 1'b0 || vector !== 8'h00 || vector_oe !== 1'b0 || init_done !== 1'b0) begin
         fails++; $display("FAIL async_rst_outs: got int %b vec %h oe %b done %b exp 0 00 0 0", int_out, vector, vector_oe, init_done); end
      inta_n = 1'b1;
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk); inta_n = 1'b0;
      @(negedge clk); #1;
      tests++; if (isr !== 8'h00 || clr_irr !== 8'h00 || int_out !== 1'b0) begin
         fails++; $display("FAIL post_rst_ignored: got isr %h clr %h int %b exp 00 00 0", isr, clr_irr, int_out); end
      inta_n = 1'b1; irr = 8'h00;
   endtask

   initial begin
      test_reset();
      test_init();
      test_ack_sequence();
      test_eoi();
      test_spurious();
      test_same_cycle_eoi_set();
      test_aeoi();
      test_icw1_abort();
      test_async_reset();
      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
